// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared definitions for the WS2812 frame sequencer.
//   state_t           controller state encoding (IDLE/FETCH/SEND/LATCH)
//   PIX_W, *_LSB      pixel width and GRB field offsets (G is sent first)
//   SLOTS_PER_BIT     time slots per WS2812 bit
//   T0H/T1H_SLOTS     high slots for a 0 bit / 1 bit
//   slot_level()      line level for a given slot of a given bit value
package ws2812_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  localparam int PIX_W = 24;
  localparam int G_LSB = 16;
  localparam int R_LSB = 8;
  localparam int B_LSB = 0;

  localparam int SLOTS_PER_BIT = 4;
  localparam int T0H_SLOTS     = 1;
  localparam int T1H_SLOTS     = 2;

  // High for the first T0H/T1H slots of a bit, low for the rest.
  function automatic logic slot_level(input logic [1:0] slot, input logic bit_val);
    logic [1:0] high_slots;
    high_slots = bit_val ? 2'(T1H_SLOTS) : 2'(T0H_SLOTS);
    return (slot < high_slots);
  endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// ws2812_bit_tx: emits one slot-coded WS2812 bit per load strobe.
//   CLK, RST_N  clock, asynchronous active-low reset
//   load        start a new bit on the next cycle (may coincide with bit_done)
//   bit_val     value of the bit being loaded
//   line        registered, un-inverted line level
//   bit_done    high during the last cycle of the current bit
module ws2812_bit_tx
  import ws2812_pkg::*;
#(
  parameter int SLOT_DIV = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic load,
  input  logic bit_val,
  output logic line,
  output logic bit_done
);

  localparam int DIV_W = (SLOT_DIV > 1) ? $clog2(SLOT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLOT_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [1:0]       SLOT_LAST = 2'(SLOTS_PER_BIT - 1);

  logic [DIV_W-1:0] div_r;
  logic [1:0]       slot_r;
  logic             active_r;
  logic             bit_r;
  logic             line_r;

  // Slot divider and slot counter; the line level is registered per slot.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_r    <= {DIV_W{1'b0}};
      slot_r   <= 2'd0;
      active_r <= 1'b0;
      bit_r    <= 1'b0;
      line_r   <= 1'b0;
    end else if (load) begin
      active_r <= 1'b1;
      bit_r    <= bit_val;
      div_r    <= {DIV_W{1'b0}};
      slot_r   <= 2'd0;
      line_r   <= slot_level(2'd0, bit_val);
    end else if (active_r) begin
      if (div_r == DIV_LAST) begin
        div_r <= {DIV_W{1'b0}};
        if (slot_r == SLOT_LAST) begin
          // No follow-on load: go quiet with the line low.
          active_r <= 1'b0;
          line_r   <= 1'b0;
        end else begin
          slot_r <= slot_r + 2'd1;
          line_r <= slot_level(slot_r + 2'd1, bit_r);
        end
      end else begin
        div_r <= div_r + DIV_ONE;
      end
    end
  end

  assign line     = line_r;
  assign bit_done = active_r & (slot_r == SLOT_LAST) & (div_r == DIV_LAST);

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// ws2812_frame_ctrl: fetches NUM_LEDS GRB pixels and streams them to a WS2812 chain.
//   CLK, RST_N             clock, asynchronous active-low reset
//   START, NUM_LEDS        frame request (IDLE only) and pixel count
//   PIX_DATA/VALID/READY   pixel source handshake, PIX_INDEX = requested pixel
//   BUSY, DONE, UNDERRUN   frame status (UNDERRUN is sticky until next START)
//   DOUT                   pad drive, inverted when INVERT=1
module ws2812_frame_ctrl
  import ws2812_pkg::*;
#(
  parameter int SLOT_DIV     = 4,
  parameter int RESET_CYCLES = 960,
  parameter int LED_W        = 8,
  parameter bit INVERT       = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [LED_W-1:0] NUM_LEDS,
  input  logic [PIX_W-1:0] PIX_DATA,
  input  logic             PIX_VALID,
  output logic             PIX_READY,
  output logic [LED_W-1:0] PIX_INDEX,
  output logic             BUSY,
  output logic             DONE,
  output logic             UNDERRUN,
  output logic             DOUT
);

  localparam int LAT_W = $clog2(RESET_CYCLES + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RESET_CYCLES - 1);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
  localparam logic [LED_W-1:0] IDX_ONE  = LED_W'(1);
  localparam logic [4:0]       BIT_TOP  = 5'(PIX_W - 1);

  state_t           state_r;
  logic [LED_W-1:0] num_r;
  logic [PIX_W-1:0] shift_r;
  logic [PIX_W-1:0] hold_r;
  logic             hold_valid_r;
  logic             last_pix_r;
  logic [4:0]       bit_cnt_r;
  logic [LAT_W-1:0] lat_cnt_r;

  logic             hs_s;
  logic             more_s;
  logic             avail_s;
  logic [PIX_W-1:0] next_pix_s;
  logic             load_s;
  logic             tx_bit_s;
  logic             line_s;
  logic             bit_done_s;

  assign hs_s = PIX_VALID & PIX_READY;

  // Next-bit selection for the bit transmitter, plus prefetch bookkeeping.
  always_comb begin
    more_s     = ({1'b0, PIX_INDEX} + {{LED_W{1'b0}}, 1'b1}) < {1'b0, num_r};
    avail_s    = hold_valid_r | hs_s;
    next_pix_s = hold_valid_r ? hold_r : PIX_DATA;
    load_s     = 1'b0;
    tx_bit_s   = 1'b0;
    case (state_r)
      ST_FETCH: begin
        if (hs_s) begin
          load_s   = 1'b1;
          tx_bit_s = PIX_DATA[PIX_W-1];
        end else begin
          load_s   = 1'b0;
          tx_bit_s = 1'b0;
        end
      end
      ST_SEND: begin
        if (bit_done_s && (bit_cnt_r != 5'd0)) begin
          load_s   = 1'b1;
          tx_bit_s = shift_r[PIX_W-2];
        end else if (bit_done_s && !last_pix_r && avail_s) begin
          // Pixel boundary: the next pixel follows with no gap.
          load_s   = 1'b1;
          tx_bit_s = next_pix_s[PIX_W-1];
        end else begin
          load_s   = 1'b0;
          tx_bit_s = 1'b0;
        end
      end
      default: begin
        load_s   = 1'b0;
        tx_bit_s = 1'b0;
      end
    endcase
  end

  // Frame FSM with registered handshake and status outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r      <= ST_IDLE;
      PIX_READY    <= 1'b0;
      PIX_INDEX    <= {LED_W{1'b0}};
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      UNDERRUN     <= 1'b0;
      num_r        <= {LED_W{1'b0}};
      shift_r      <= {PIX_W{1'b0}};
      hold_r       <= {PIX_W{1'b0}};
      hold_valid_r <= 1'b0;
      last_pix_r   <= 1'b0;
      bit_cnt_r    <= 5'd0;
      lat_cnt_r    <= {LAT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            num_r        <= NUM_LEDS;
            UNDERRUN     <= 1'b0;
            BUSY         <= 1'b1;
            PIX_INDEX    <= {LED_W{1'b0}};
            hold_valid_r <= 1'b0;
            if (NUM_LEDS == {LED_W{1'b0}}) begin
              state_r   <= ST_LATCH;
              lat_cnt_r <= LAT_LOAD;
              DONE      <= (LAT_LOAD == {LAT_W{1'b0}});
            end else begin
              state_r   <= ST_FETCH;
              PIX_READY <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (hs_s) begin
            shift_r    <= PIX_DATA;
            bit_cnt_r  <= BIT_TOP;
            state_r    <= ST_SEND;
            // Bit 23 starts now: request the next pixel straight away.
            last_pix_r <= ~more_s;
            PIX_READY  <= more_s;
            if (more_s) begin
              PIX_INDEX <= PIX_INDEX + IDX_ONE;
            end
          end
        end
        ST_SEND: begin
          if (bit_done_s && (bit_cnt_r != 5'd0)) begin
            shift_r   <= {shift_r[PIX_W-2:0], 1'b0};
            bit_cnt_r <= bit_cnt_r - 5'd1;
            if (hs_s) begin
              hold_r       <= PIX_DATA;
              hold_valid_r <= 1'b1;
              PIX_READY    <= 1'b0;
            end
          end else if (bit_done_s) begin
            if (last_pix_r) begin
              state_r   <= ST_LATCH;
              lat_cnt_r <= LAT_LOAD;
              DONE      <= (LAT_LOAD == {LAT_W{1'b0}});
            end else if (avail_s) begin
              shift_r      <= next_pix_s;
              bit_cnt_r    <= BIT_TOP;
              hold_valid_r <= 1'b0;
              last_pix_r   <= ~more_s;
              PIX_READY    <= more_s;
              if (more_s) begin
                PIX_INDEX <= PIX_INDEX + IDX_ONE;
              end
            end else begin
              // Source missed the boundary; PIX_READY stays up for the pending pixel.
              state_r  <= ST_FETCH;
              UNDERRUN <= 1'b1;
            end
          end else if (hs_s) begin
            hold_r       <= PIX_DATA;
            hold_valid_r <= 1'b1;
            PIX_READY    <= 1'b0;
          end
        end
        ST_LATCH: begin
          if (lat_cnt_r == {LAT_W{1'b0}}) begin
            state_r <= ST_IDLE;
            DONE    <= 1'b0;
            BUSY    <= 1'b0;
          end else begin
            lat_cnt_r <= lat_cnt_r - LAT_ONE;
            DONE      <= (lat_cnt_r == LAT_ONE);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  ws2812_bit_tx #(
    .SLOT_DIV (SLOT_DIV)
  ) u_bit_tx (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (load_s),
    .bit_val  (tx_bit_s),
    .line     (line_s),
    .bit_done (bit_done_s)
  );

  // Only a static inverter sits between the line flop and the pad.
  assign DOUT = line_s ^ INVERT;

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
module tb_ws2812_frame_ctrl;
  import ws2812_pkg::*;

  localparam int SLOT_DIV     = 4;
  localparam int RESET_CYCLES = 960;
  localparam int LED_W        = 8;
  localparam bit INV          = 1'b1;
  localparam int BIT_CYC      = 4 * SLOT_DIV;
  localparam int HI0          = 1 * SLOT_DIV;
  localparam int HI1          = 2 * SLOT_DIV;
  localparam int PIX_CYC      = 24 * BIT_CYC;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             START = 1'b0;
  logic [LED_W-1:0] NUM_LEDS = 8'd0;
  logic [23:0]      PIX_DATA = 24'd0;
  logic             PIX_VALID = 1'b0;
  logic             PIX_READY;
  logic [LED_W-1:0] PIX_INDEX;
  logic             BUSY, DONE, UNDERRUN, DOUT;

  ws2812_frame_ctrl #(
    .SLOT_DIV(SLOT_DIV), .RESET_CYCLES(RESET_CYCLES), .LED_W(LED_W), .INVERT(INV)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .NUM_LEDS(NUM_LEDS),
    .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
    .PIX_INDEX(PIX_INDEX), .BUSY(BUSY), .DONE(DONE), .UNDERRUN(UNDERRUN), .DOUT(DOUT)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line monitor: decodes the waveform into rising-edge times and high widths.
  int   cyc = 0;
  int   rise_q[$];
  int   hl_q[$];
  int   hi_len = 0;
  int   last_fall = 0;
  int   done_cnt = 0, done_cyc = 0, ready_cnt = 0, busy_cnt = 0;
  logic prev_line = 1'b0;
  logic mon_line;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    mon_line = DOUT ^ INV;
    if (mon_line && !prev_line) begin
      rise_q.push_back(cyc);
      hi_len = 1;
    end else if (mon_line) begin
      hi_len++;
    end
    if (!mon_line && prev_line) begin
      hl_q.push_back(hi_len);
      last_fall = cyc;
    end
    if (DONE) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (PIX_READY) ready_cnt++;
    if (BUSY) busy_cnt++;
    prev_line = mon_line;
  end

  logic [23:0] pix [8];
  int          dly [8];

  task automatic fill(input int n, input bit ulate);
    bit any_late;
    any_late = 1'b0;
    for (int k = 0; k < n; k++) begin
      pix[k] = 24'($urandom);
      if (k == 0) dly[k] = $urandom_range(0, 20);
      else if (ulate && ($urandom_range(0, 1) == 1)) begin
        dly[k] = $urandom_range(430, 520);
        any_late = 1'b1;
      end else dly[k] = $urandom_range(0, 100);
    end
    if (ulate && !any_late && n >= 2) dly[n-1] = $urandom_range(430, 520);
  endtask

  // Pixel source: waits for PIX_READY, then offers pixel k after dly[k] cycles.
  task automatic feed(input int n);
    for (int k = 0; k < n; k++) begin
      int t;
      t = 0;
      while (!PIX_READY && t < 5000) begin
        @(negedge CLK);
        t++;
      end
      if (!PIX_READY) begin
        check_val("ready_timeout", {31'd0, PIX_READY}, 32'd1);
        return;
      end
      repeat (dly[k]) @(negedge CLK);
      check_val("pix_index", {24'd0, PIX_INDEX}, k);
      PIX_DATA  = pix[k];
      PIX_VALID = 1'b1;
      @(negedge CLK);
      PIX_VALID = 1'b0;
    end
  endtask

  task automatic run_frame(input int n, input bit inject);
    int b0, r0, dc0, rc0, bc0, start_cyc, t, n_under, n_gap, n_odd, max_iv, iv, exp_low;
    logic [23:0] w;
    n_under = 0;
    for (int k = 1; k < n; k++) if (dly[k] > PIX_CYC) n_under++;
    @(negedge CLK);
    b0 = hl_q.size(); r0 = rise_q.size(); dc0 = done_cnt; rc0 = ready_cnt; bc0 = busy_cnt;
    NUM_LEDS  = 8'(n);
    START     = 1'b1;
    start_cyc = cyc;
    @(negedge CLK);
    START    = 1'b0;
    NUM_LEDS = 8'($urandom_range(1, 6));
    fork
      feed(n);
      begin
        if (inject) begin
          repeat (100) @(negedge CLK);
          NUM_LEDS = 8'(n + 2);
          START = 1'b1;
          @(negedge CLK);
          START = 1'b0;
          repeat (dly[0] + PIX_CYC * n + 300) @(negedge CLK);
          NUM_LEDS = 8'(n + 3);
          START = 1'b1;
          @(negedge CLK);
          START = 1'b0;
        end
      end
    join
    t = 0;
    while (done_cnt == dc0 && t < 30000) begin
      @(negedge CLK);
      t++;
    end
    repeat (20) @(negedge CLK);
    check_val("done_count", done_cnt - dc0, 1);
    check_val("busy_after", {31'd0, BUSY}, 0);
    check_val("bit_count", hl_q.size() - b0, 24 * n);
    n_odd = 0;
    for (int i = b0; i < hl_q.size(); i++) if (hl_q[i] != HI0 && hl_q[i] != HI1) n_odd++;
    check_val("slot_width_errs", n_odd, 0);
    for (int k = 0; k < n; k++) begin
      if (hl_q.size() >= b0 + 24 * (k + 1)) begin
        w = 24'd0;
        for (int j = 0; j < 24; j++) w = {w[22:0], (hl_q[b0 + 24 * k + j] == HI1)};
        check_val($sformatf("pixel%0d", k), {8'd0, w}, {8'd0, pix[k]});
      end
    end
    if (n > 0 && rise_q.size() > r0) begin
      check_val("first_edge_lat", rise_q[r0] - start_cyc, 2 + dly[0]);
      n_gap = 0;
      max_iv = 0;
      for (int i = r0 + 1; i < rise_q.size(); i++) begin
        iv = rise_q[i] - rise_q[i-1];
        if (iv != BIT_CYC) n_gap++;
        if (iv > max_iv) max_iv = iv;
      end
      check_val("gap_count", n_gap, n_under);
      if (n_under > 0) check_val("underrun_wait", {31'd0, (max_iv >= BIT_CYC + 40)}, 1);
      exp_low = BIT_CYC - (pix[n-1][0] ? HI1 : HI0) + RESET_CYCLES;
      check_val("latch_low", done_cyc - last_fall + 1, exp_low);
    end
    check_val("underrun_flag", {31'd0, UNDERRUN}, {31'd0, (n_under > 0)});
    if (n == 0) begin
      check_val("ready_cycles", ready_cnt - rc0, 0);
      check_val("busy_cycles", busy_cnt - bc0, RESET_CYCLES);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_ready"}, {31'd0, PIX_READY}, 0);
    check_val({tag, "_index"}, {24'd0, PIX_INDEX}, 0);
    check_val({tag, "_busy"}, {31'd0, BUSY}, 0);
    check_val({tag, "_done"}, {31'd0, DONE}, 0);
    check_val({tag, "_underrun"}, {31'd0, UNDERRUN}, 0);
    check_val({tag, "_dout"}, {31'd0, DOUT}, {31'd0, INV});
  endtask

  initial begin
    int t;
    repeat (3) @(negedge CLK);
    check_reset_vals("rst");
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);

    // Single pixel G=FF: 8 one-bits then 16 zero-bits.
    pix[0] = 24'hFF << G_LSB;
    dly[0] = 0;
    run_frame(1, 1'b0);

    // Three pixels back-to-back.
    fill(3, 1'b0);
    for (int k = 0; k < 3; k++) dly[k] = 0;
    run_frame(3, 1'b0);

    // Second pixel arrives well past its boundary.
    fill(2, 1'b0);
    dly[1] = PIX_CYC + 57;
    run_frame(2, 1'b0);
    check_val("underrun_sticky", {31'd0, UNDERRUN}, 1);
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1 check_val("underrun_rst", {31'd0, UNDERRUN}, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);

    // START during SEND and LATCH is ignored.
    fill(2, 1'b0);
    run_frame(2, 1'b1);

    // Empty frame: only the latch gap.
    run_frame(0, 1'b0);

    // Reset in the middle of a high slot.
    fill(2, 1'b0);
    PIX_DATA  = pix[0];
    PIX_VALID = 1'b1;
    @(negedge CLK);
    NUM_LEDS = 8'd2;
    START    = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    t = 0;
    while (DOUT == INV && t < 100) begin
      @(negedge CLK);
      t++;
    end
    check_val("line_high_before_rst", {31'd0, DOUT}, {31'd0, ~INV});
    #2 RST_N = 1'b0;
    #1 check_reset_vals("midrst");
    @(negedge CLK);
    PIX_VALID = 1'b0;
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);
    fill(2, 1'b0);
    run_frame(2, 1'b0);

    // Randomised frames.
    for (int f = 0; f < 5; f++) begin
      int n;
      n = $urandom_range(1, 5);
      fill(n, 1'($urandom_range(0, 1)));
      run_frame(n, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
